// File: rtl/cam_pkg.sv
// Shared definitions for the OV7670 window capture block: FSM encoding,
// VGA sensor geometry and capture-mode constants.
package cam_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_FRAME = 2'd1,
        ST_CAPTURE    = 2'd2,
        ST_DONE       = 2'd3
    } cam_state_e;

    localparam int OV_COL_MAX  = 640;
    localparam int OV_LINE_MAX = 480;

    localparam logic MODE_RGB    = 1'b0;
    localparam logic MODE_Y_ONLY = 1'b1;

    // Width of a counter that must be able to hold values 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/cam_frame_ram.sv
// Simple dual-port window buffer: one write port, one registered read port.
// A read colliding with a write to the same address returns the old word.
module cam_frame_ram #(
    parameter int DEPTH = 36,
    parameter int AW    = 6
) (
    input  logic          pclk,
    input  logic          system_reset,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [15:0]   wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [15:0]   rd_data
);

    logic [15:0] mem [DEPTH];

    always_ff @(posedge pclk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Both processes sample mem before the edge, which gives read-old on collision.
    always_ff @(posedge pclk or negedge system_reset) begin
        if (!system_reset) begin
            rd_data <= '0;
        end else if (32'(rd_addr) < DEPTH) begin
            rd_data <= mem[rd_addr];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: rtl/cam_window_capture.sv
// OV7670 window grabber: after an arm, waits for a frame start and stores a
// WIN_W x WIN_H pixel window at (X_OFF, Y_OFF) into the internal frame RAM.
module cam_window_capture
    import cam_pkg::*;
#(
    parameter int WIN_W    = 6,
    parameter int WIN_H    = 6,
    parameter int X_OFF    = 0,
    parameter int Y_OFF    = 0,
    parameter int COL_MAX  = OV_COL_MAX,
    parameter int LINE_MAX = OV_LINE_MAX,
    parameter int DEPTH    = WIN_W * WIN_H,
    parameter int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          pclk,
    input  logic          system_reset,
    input  logic          vsync,
    input  logic          href,
    input  logic [7:0]    data,
    input  logic          arm,
    input  logic          mode_y_only,
    input  logic          continuous,
    input  logic [AW-1:0] rd_addr,
    output logic [15:0]   rd_data,
    output logic          busy,
    output logic          done,
    output logic          frame_done,
    output logic          error,
    output logic [7:0]    frame_cnt
);

    localparam int CW = cnt_width(COL_MAX);
    localparam int LW = cnt_width(LINE_MAX);

    cam_state_e    state, next_state;

    logic          vsync_r, vsync_d, href_r, href_d;
    logic [7:0]    data_r, hi_byte;
    logic          phase;
    logic [CW-1:0] col_cnt;
    logic [LW-1:0] line_cnt;
    logic          mode_r, cont_r;

    logic          frame_start, vsync_rise, line_end, pix_done;
    logic          in_window, we;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;
    logic          accept_arm, complete, abort;
    int            line_i, col_i, addr_i;

    // Camera inputs are registered once; data rides along so it stays aligned with href.
    always_ff @(posedge pclk or negedge system_reset) begin
        if (!system_reset) begin
            vsync_r  <= 1'b0;
            vsync_d  <= 1'b0;
            href_r   <= 1'b0;
            href_d   <= 1'b0;
            data_r   <= '0;
            hi_byte  <= '0;
            phase    <= 1'b0;
            col_cnt  <= '0;
            line_cnt <= '0;
        end else begin
            vsync_r <= vsync;
            vsync_d <= vsync_r;
            href_r  <= href;
            href_d  <= href_r;
            data_r  <= data;
            if (!href_r) begin
                phase <= 1'b0;
            end else begin
                phase <= ~phase;
                if (!phase) begin
                    hi_byte <= data_r;
                end
            end
            if (line_end) begin
                col_cnt <= '0;
            end else if (pix_done) begin
                col_cnt <= col_cnt + 1'b1;
            end
            if (frame_start) begin
                line_cnt <= '0;
            end else if (line_end) begin
                line_cnt <= line_cnt + 1'b1;
            end
        end
    end

    assign frame_start = vsync_d & ~vsync_r;
    assign vsync_rise  = ~vsync_d & vsync_r;
    assign line_end    = href_d & ~href_r;
    assign pix_done    = href_r & phase;

    always_comb begin
        line_i    = int'(line_cnt);
        col_i     = int'(col_cnt);
        in_window = (line_i >= Y_OFF) && (line_i < Y_OFF + WIN_H) &&
                    (col_i >= X_OFF) && (col_i < X_OFF + WIN_W);
        addr_i    = (line_i - Y_OFF) * WIN_W + (col_i - X_OFF);
        wr_addr   = AW'(addr_i);
        wr_data   = (mode_r == MODE_Y_ONLY) ? {8'h00, data_r} : {hi_byte, data_r};
    end

    assign we = (state == ST_CAPTURE) && pix_done && in_window;

    always_ff @(posedge pclk or negedge system_reset) begin
        if (!system_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        accept_arm = 1'b0;
        complete   = 1'b0;
        abort      = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (arm) begin
                    accept_arm = 1'b1;
                    next_state = ST_WAIT_FRAME;
                end
            end
            ST_WAIT_FRAME: begin
                if (frame_start) begin
                    next_state = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                // The final word wins over a coincident vsync rise.
                if (we && (wr_addr == AW'(DEPTH - 1))) begin
                    complete   = 1'b1;
                    next_state = cont_r ? ST_WAIT_FRAME : ST_DONE;
                end else if (vsync_rise) begin
                    abort      = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge system_reset) begin
        if (!system_reset) begin
            done       <= 1'b0;
            error      <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
            mode_r     <= MODE_RGB;
            cont_r     <= 1'b0;
        end else begin
            frame_done <= complete;
            if (accept_arm) begin
                done   <= 1'b0;
                error  <= 1'b0;
                mode_r <= mode_y_only;
                cont_r <= continuous;
            end
            if (complete) begin
                done      <= 1'b1;
                frame_cnt <= frame_cnt + 8'd1;
            end
            if (abort) begin
                error <= 1'b1;
            end
        end
    end

    assign busy = (state == ST_WAIT_FRAME) || (state == ST_CAPTURE);

    cam_frame_ram #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_ram (
        .pclk        (pclk),
        .system_reset(system_reset),
        .we          (we),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data)
    );

endmodule
